eq_ui_controller: RTL
=====================

# eq_ui_controller

Key-driven user-interface controller that owns all user-visible equaliser settings. It converts single-cycle key pulses into the top-level UI state, menu cursor, selected band, per-band gains, output offset and play enable. Its registered outputs feed the seven-segment display decoder directly and feed the EQ datapath through a packed gain table plus an update strobe. It sits between the key debouncers and both the display and EQ stages.

## Interface
- NUM_BANDS, 6, number of EQ bands; band index range 1..NUM_BANDS
- GAIN_MAX, 12, gain saturation magnitude in dB; gain range is -GAIN_MAX..+GAIN_MAX
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous and active-high
- i_init_done  in  1  level; codec initialisation finished
- i_key_up, i_key_down, i_key_sel, i_key_back, i_key_menu  in  1 each  debounced single-cycle key pulses
- o_state  out  3  UI state: 0 INIT, 1 PLAY, 2 MENU, 3 BAND, 4 GAIN
- o_menu_state  out  3  menu cursor: 0 EQ, 1 OFFSET, 2 RESET
- o_band  out  3  selected band, 1..6 (100, 200, 400, 800, 1600, 3200 Hz)
- o_gain  out  32  gain of the selected band, two's complement, sign-extended from 5 bits
- o_offset  out  3  output offset setting, 0..7
- o_play_enable  out  1  playback enabled
- o_gain_table  out  5*NUM_BANDS  packed signed gains; band b occupies bits [5b-1 : 5b-5]
- o_eq_update  out  1  one-cycle strobe; EQ coefficients or offset changed

## Operation
- Only one key action is taken per cycle. Priority is back > sel > menu > up > down; lower-priority pulses in the same cycle are dropped.
- INIT: stay until i_init_done=1, then go to PLAY. All keys are ignored.
- PLAY:
  - sel toggles o_play_enable.
  - menu goes to MENU with o_menu_state=0.
  - up, down and back do nothing.
- MENU:
  - up and down move the cursor through 0..2 with wrap (2 up→0, 0 down→2).
  - back goes to PLAY.
  - sel with cursor 0 (EQ) goes to BAND; o_band keeps its last value.
  - sel with cursor 1 (OFFSET) increments o_offset modulo 8 (7→0), pulses o_eq_update, and stays in MENU.
  - sel with cursor 2 (RESET) clears all gains and o_offset to 0, pulses o_eq_update, and goes to PLAY. o_play_enable is unchanged.
- BAND:
  - up and down move through 1..6 with wrap (6 up→1, 1 down→6).
  - sel goes to GAIN.
  - back goes to MENU.
- GAIN:
  - up adds 1 to the selected band's gain, saturating at +12.
  - down subtracts 1, saturating at -12.
  - o_eq_update pulses only when the stored value actually changes; a saturated press gives no strobe.
  - sel and back both return to BAND.
- o_gain always reflects the selected band's gain, in every state.
- The menu key is ignored everywhere except PLAY.
- Unused o_state encodings 5..7 are unreachable. If one is ever present, the next cycle forces INIT.

## Timing
- Reset values:
  - o_state=0, o_menu_state=0, o_band=1, o_offset=0, o_play_enable=0, o_eq_update=0.
  - All gains are 0, so o_gain=0 and o_gain_table=0.
- All outputs are registered. A key pulse at edge N is reflected on the outputs after edge N+1, with one cycle of latency.
- o_eq_update asserts in the same cycle the new o_gain_table or o_offset value first appears. It stays high for exactly one cycle.
- Back-to-back key pulses on consecutive cycles are each processed. No minimum gap is required.
- If i_rst is asserted mid-operation, it overrides any key on that edge, and all state returns to reset values.
- If i_init_done deasserts after INIT, it is ignored.

## Structure
- The shared package eq_ui_pkg holds:
  - the ui_state_t enum (INIT, PLAY, MENU, BAND, GAIN), also used by the display decoder;
  - the menu_item_t enum (EQ, OFFSET, RESET);
  - the constants NUM_BANDS, GAIN_MAX and GAIN_W=5.
- One sub-module, eq_gain_table:
  - holds NUM_BANDS signed 5-bit registers;
  - takes inputs band, inc, dec and clear_all, with synchronous reset;
  - drives the packed table, the selected gain, and a "changed" flag.
- The top level contains the FSM, the menu, band and offset counters, and the strobe register.

## Test plan
- Reset, then i_init_done=1 → o_state=1 one cycle later. Then sel → o_play_enable=1; sel again → 0.
- menu, sel (EQ), up×2, sel, up×15 → o_state=4, o_band=3, o_gain=12. Exactly 12 o_eq_update pulses occur. o_gain_table bits [14:10] = 5'b01100.
- In GAIN on band 1, down×14 → o_gain=32'hFFFF_FFF4 (-12), with 12 strobes.
- In MENU, down from cursor 0 → 2. Then sel → all gains 0, o_offset=0, one strobe, o_state=1.
- In MENU at cursor 1, sel×9 → o_offset=1, 9 strobes.
- up and back pulsed in the same cycle while in BAND → back wins: o_state=2 and o_band unchanged. Then reset asserted mid-sequence → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/eq_ui_pkg.sv
// Shared definitions for the equaliser user interface.
// Holds the UI state and menu item encodings (also used by the display
// decoder), the band/gain sizing constants and the signed gain type.
package eq_ui_pkg;

  localparam int NUM_BANDS = 6;
  localparam int GAIN_MAX  = 12;
  localparam int GAIN_W    = 5;
  localparam int BAND_W    = 3;
  localparam int TABLE_W   = GAIN_W * NUM_BANDS;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    PLAY = 3'd1,
    MENU = 3'd2,
    BAND = 3'd3,
    GAIN = 3'd4
  } ui_state_t;

  typedef enum logic [1:0] {
    EQ     = 2'd0,
    OFFSET = 2'd1,
    RESET  = 2'd2
  } menu_item_t;

  typedef logic signed [GAIN_W-1:0] gain_t;

  localparam gain_t GAIN_HI = gain_t'(GAIN_MAX);
  localparam gain_t GAIN_LO = gain_t'(-GAIN_MAX);

endpackage

// File: rtl/eq_ui_controller_if.sv
// Key and settings bundle between the key debouncers, the UI controller and
// the display/EQ stages.
//   master : key source / settings consumer (drives keys and init_done)
//   slave  : the UI controller (drives UI state and settings)
interface eq_ui_controller_if;
  import eq_ui_pkg::*;

  logic               i_init_done;
  logic               i_key_up;
  logic               i_key_down;
  logic               i_key_sel;
  logic               i_key_back;
  logic               i_key_menu;
  logic [2:0]         o_state;
  logic [2:0]         o_menu_state;
  logic [2:0]         o_band;
  logic [31:0]        o_gain;
  logic [2:0]         o_offset;
  logic               o_play_enable;
  logic [TABLE_W-1:0] o_gain_table;
  logic               o_eq_update;

  modport master (
    output i_init_done, i_key_up, i_key_down, i_key_sel, i_key_back, i_key_menu,
    input  o_state, o_menu_state, o_band, o_gain, o_offset, o_play_enable,
           o_gain_table, o_eq_update
  );

  modport slave (
    input  i_init_done, i_key_up, i_key_down, i_key_sel, i_key_back, i_key_menu,
    output o_state, o_menu_state, o_band, o_gain, o_offset, o_play_enable,
           o_gain_table, o_eq_update
  );

endinterface

// File: rtl/eq_gain_table.sv
// Per-band saturating gain registers.
// Ports:
//   clk, srst   clock, synchronous active-high reset
//   band        selected band, 1..NUM_BANDS
//   inc, dec    step the selected band's gain by +1 / -1 (saturating)
//   clear_all   zero every band
//   gain_table  packed gains, band b at bits [5b-1 : 5b-5]
//   sel_gain    gain of the selected band
//   changed     the requested inc/dec will actually alter the stored value
module eq_gain_table
  import eq_ui_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic [BAND_W-1:0]  band,
  input  logic               inc,
  input  logic               dec,
  input  logic               clear_all,
  output logic [TABLE_W-1:0] gain_table,
  output gain_t              sel_gain,
  output logic               changed
);

  gain_t gains [NUM_BANDS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : gen_band
      gain_t gain_reg;
      logic  hit;

      assign hit = (band == BAND_W'(gi + 1));

      always_ff @(posedge clk) begin
        if (srst || clear_all) begin
          gain_reg <= '0;
        end else if (hit && inc && gain_reg != GAIN_HI) begin
          gain_reg <= gain_reg + gain_t'(1);
        end else if (hit && dec && gain_reg != GAIN_LO) begin
          gain_reg <= gain_reg - gain_t'(1);
        end
      end

      assign gains[gi] = gain_reg;
      assign gain_table[gi*GAIN_W +: GAIN_W] = gain_reg;
    end
  endgenerate

  always_comb begin
    sel_gain = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (band == BAND_W'(b + 1)) sel_gain = gains[b];
    end
  end

  // Saturated presses must not strobe the EQ datapath.
  assign changed = (inc && sel_gain != GAIN_HI) || (dec && sel_gain != GAIN_LO);

endmodule

// File: rtl/eq_ui_controller.sv
// Key-driven equaliser UI controller.
// Turns single-cycle key pulses into UI state, menu cursor, selected band,
// per-band gains, output offset and play enable. All settings are registered;
// o_eq_update pulses for one cycle alongside any new gain table/offset.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           eq_ui_controller_if.slave: keys/init_done in, settings out
module eq_ui_controller
  import eq_ui_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  eq_ui_controller_if.slave  bus
);

  ui_state_t         state_reg, state_next;
  menu_item_t        menu_reg, menu_next;
  logic [BAND_W-1:0] band_reg, band_next;
  logic [2:0]        offset_reg, offset_next;
  logic              play_reg, play_next;
  logic              update_reg, update_next;

  logic  gain_inc, gain_dec, gain_clear, offset_bump;
  logic  gain_changed;
  gain_t sel_gain;

  // One action per cycle: back > sel > menu > up > down.
  logic act_back, act_sel, act_menu, act_up, act_down;
  assign act_back = bus.i_key_back;
  assign act_sel  = bus.i_key_sel  && !act_back;
  assign act_menu = bus.i_key_menu && !bus.i_key_sel && !act_back;
  assign act_up   = bus.i_key_up   && !bus.i_key_menu && !bus.i_key_sel && !act_back;
  assign act_down = bus.i_key_down && !bus.i_key_up && !bus.i_key_menu
                    && !bus.i_key_sel && !act_back;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= INIT;
      menu_reg   <= EQ;
      band_reg   <= BAND_W'(1);
      offset_reg <= '0;
      play_reg   <= 1'b0;
      update_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      menu_reg   <= menu_next;
      band_reg   <= band_next;
      offset_reg <= offset_next;
      play_reg   <= play_next;
      update_reg <= update_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    menu_next   = menu_reg;
    band_next   = band_reg;
    offset_next = offset_reg;
    play_next   = play_reg;
    gain_inc    = 1'b0;
    gain_dec    = 1'b0;
    gain_clear  = 1'b0;
    offset_bump = 1'b0;

    case (state_reg)
      INIT: begin
        if (bus.i_init_done) state_next = PLAY;
      end
      PLAY: begin
        if (act_sel) begin
          play_next = !play_reg;
        end else if (act_menu) begin
          state_next = MENU;
          menu_next  = EQ;
        end
      end
      MENU: begin
        if (act_back) begin
          state_next = PLAY;
        end else if (act_sel) begin
          case (menu_reg)
            EQ:     state_next = BAND;
            OFFSET: begin
              offset_next = offset_reg + 3'd1;
              offset_bump = 1'b1;
            end
            RESET: begin
              gain_clear  = 1'b1;
              offset_next = '0;
              state_next  = PLAY;
            end
            default: menu_next = EQ;
          endcase
        end else if (act_up) begin
          menu_next = (menu_reg == RESET) ? EQ : menu_item_t'(menu_reg + 2'd1);
        end else if (act_down) begin
          menu_next = (menu_reg == EQ) ? RESET : menu_item_t'(menu_reg - 2'd1);
        end
      end
      BAND: begin
        if (act_back) begin
          state_next = MENU;
        end else if (act_sel) begin
          state_next = GAIN;
        end else if (act_up) begin
          band_next = (band_reg == BAND_W'(NUM_BANDS)) ? BAND_W'(1) : band_reg + BAND_W'(1);
        end else if (act_down) begin
          band_next = (band_reg == BAND_W'(1)) ? BAND_W'(NUM_BANDS) : band_reg - BAND_W'(1);
        end
      end
      GAIN: begin
        if (act_back || act_sel) begin
          state_next = BAND;
        end else if (act_up) begin
          gain_inc = 1'b1;
        end else if (act_down) begin
          gain_dec = 1'b1;
        end
      end
      default: state_next = INIT;  // recover from unreachable encodings
    endcase
  end

  // Registered together with the gain/offset so the strobe lines up with the
  // first cycle the new value is visible.
  assign update_next = gain_changed || gain_clear || offset_bump;

  eq_gain_table u_gain_table (
    .clk        (i_clk),
    .srst       (i_rst),
    .band       (band_reg),
    .inc        (gain_inc),
    .dec        (gain_dec),
    .clear_all  (gain_clear),
    .gain_table (bus.o_gain_table),
    .sel_gain   (sel_gain),
    .changed    (gain_changed)
  );

  assign bus.o_state       = state_reg;
  assign bus.o_menu_state  = {1'b0, menu_reg};
  assign bus.o_band        = band_reg;
  assign bus.o_gain        = {{(32-GAIN_W){sel_gain[GAIN_W-1]}}, sel_gain};
  assign bus.o_offset      = offset_reg;
  assign bus.o_play_enable = play_reg;
  assign bus.o_eq_update   = update_reg;

endmodule
